// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared constants, state encoding and source-select codes for the OFDM TX sequencer
package ofdm_pkg;

    localparam int NFFT    = 64;
    localparam int CP_LEN  = 16;
    localparam int PRE_LEN = 160;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHORT     = 3'd1,
        ST_LONG      = 3'd2,
        ST_DATA_WAIT = 3'd3,
        ST_DATA      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    localparam logic [1:0] SRC_ZERO  = 2'd0;
    localparam logic [1:0] SRC_SHORT = 2'd1;
    localparam logic [1:0] SRC_LONG  = 2'd2;
    localparam logic [1:0] SRC_DATA  = 2'd3;

    // Samples per data symbol including the cyclic prefix
    function automatic int sym_len(input int cp_len, input int nfft);
        return cp_len + nfft;
    endfunction

endpackage

// File: rtl/ofdm_cp_addr_gen.sv
// rtl/ofdm_cp_addr_gen.sv - per-symbol sample counter and cyclic-prefix buffer address
module ofdm_cp_addr_gen #(
    parameter int NFFT   = ofdm_pkg::NFFT,
    parameter int CP_LEN = ofdm_pkg::CP_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    output logic                    first,
    output logic                    last,
    output logic [$clog2(NFFT)-1:0] buf_addr
);
    import ofdm_pkg::*;

    localparam int SYM_LEN = sym_len(CP_LEN, NFFT);
    localparam int KW      = $clog2(SYM_LEN);
    localparam int AW      = $clog2(NFFT);
    localparam logic [KW-1:0] K_LAST = KW'(SYM_LEN - 1);
    // Starting offset so that k=0 reads the tail of the symbol (the prefix)
    localparam logic [KW-1:0] K_OFFS = KW'(NFFT - CP_LEN);

    logic [KW-1:0] k_q, k_d;

    assign first = (k_q == '0);
    assign last  = (k_q == K_LAST);
    // NFFT is a power of two, so dropping the upper bits is the mod-NFFT wrap
    assign buf_addr = AW'(k_q + K_OFFS);

    // Next sample index: load parks at zero, step walks 0..SYM_LEN-1 and wraps
    always_comb begin
        k_d = k_q;
        if (load) begin
            k_d = '0;
        end else if (step) begin
            k_d = last ? '0 : k_q + KW'(1);
        end
    end

    // Sample index register
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/ofdm_tx_sequencer.sv
// rtl/ofdm_tx_sequencer.sv - OFDM frame sequencer: preambles, IFFT symbol requests, CP read addressing
module ofdm_tx_sequencer #(
    parameter int NFFT    = ofdm_pkg::NFFT,
    parameter int CP_LEN  = ofdm_pkg::CP_LEN,
    parameter int PRE_LEN = ofdm_pkg::PRE_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    start,
    input  logic [7:0]              num_symbols,
    input  logic                    sym_ready,
    output logic                    sym_req,
    output logic                    sym_ack,
    output logic [1:0]              src_sel,
    output logic [7:0]              rom_addr,
    output logic [$clog2(NFFT)-1:0] buf_addr,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);
    import ofdm_pkg::*;

    localparam int AW = $clog2(NFFT);
    localparam logic [7:0] ROM_LAST = 8'(PRE_LEN - 1);

    state_t        state_q, state_d;
    logic [7:0]    rom_q, rom_d;
    logic [7:0]    remain_q, remain_d;
    logic          underrun_q, underrun_d;

    logic          cp_load;
    logic          cp_step;
    logic          cp_first;
    logic          cp_last;
    logic [AW-1:0] cp_addr;

    ofdm_cp_addr_gen #(
        .NFFT   (NFFT),
        .CP_LEN (CP_LEN)
    ) u_cp_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (cp_load),
        .step     (cp_step),
        .first    (cp_first),
        .last     (cp_last),
        .buf_addr (cp_addr)
    );

    assign rom_addr = rom_q;
    assign buf_addr = (state_q == ST_DATA) ? cp_addr : '0;
    assign underrun = underrun_q;

    // Frame FSM: next state, counters and decoded outputs; pulses are qualified by en
    always_comb begin
        state_d      = state_q;
        rom_d        = rom_q;
        remain_d     = remain_q;
        underrun_d   = underrun_q;
        cp_load      = (state_q != ST_DATA);
        cp_step      = 1'b0;
        src_sel      = SRC_ZERO;
        sample_valid = 1'b0;
        busy         = 1'b0;
        sym_req      = 1'b0;
        sym_ack      = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && start) begin
                    state_d    = ST_SHORT;
                    rom_d      = 8'd0;
                    remain_d   = num_symbols;
                    underrun_d = 1'b0;
                end
            end
            ST_SHORT: begin
                src_sel      = SRC_SHORT;
                sample_valid = 1'b1;
                busy         = 1'b1;
                if (en) begin
                    if (rom_q == ROM_LAST) begin
                        rom_d   = 8'd0;
                        state_d = ST_LONG;
                    end else begin
                        rom_d = rom_q + 8'd1;
                    end
                end
            end
            ST_LONG: begin
                src_sel      = SRC_LONG;
                sample_valid = 1'b1;
                busy         = 1'b1;
                // Prefetch symbol 0 while the long preamble plays out
                sym_req      = en && (rom_q == 8'd0) && (remain_q != 8'd0);
                if (en) begin
                    if (rom_q == ROM_LAST) begin
                        rom_d = 8'd0;
                        if (remain_q == 8'd0) begin
                            state_d = ST_FINISH;
                        end else if (sym_ready) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d    = ST_DATA_WAIT;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        rom_d = rom_q + 8'd1;
                    end
                end
            end
            ST_DATA_WAIT: begin
                busy = 1'b1;
                if (en && sym_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                src_sel      = SRC_DATA;
                sample_valid = 1'b1;
                busy         = 1'b1;
                cp_step      = en;
                sym_ack      = en && cp_first;
                // Request the next symbol only once this one is consumed: one outstanding max
                sym_req      = en && cp_first && (remain_q > 8'd1);
                if (en && cp_last) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = ST_FINISH;
                    end else if (sym_ready) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d    = ST_DATA_WAIT;
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                done = en;
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rom_q      <= 8'd0;
            remain_q   <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_q      <= rom_d;
            remain_q   <= remain_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_ofdm_tx_sequencer.sv
// tb/tb_ofdm_tx_sequencer.sv - scoreboard bench for ofdm_tx_sequencer with directed frames
module tb_ofdm_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       start;
    logic [7:0] num_symbols;
    logic       sym_ready;
    logic       sym_req;
    logic       sym_ack;
    logic [1:0] src_sel;
    logic [7:0] rom_addr;
    logic [5:0] buf_addr;
    logic       sample_valid;
    logic       busy;
    logic       done;
    logic       underrun;

    ofdm_tx_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .start        (start),
        .num_symbols  (num_symbols),
        .sym_ready    (sym_ready),
        .sym_req      (sym_req),
        .sym_ack      (sym_ack),
        .src_sel      (src_sel),
        .rom_addr     (rom_addr),
        .buf_addr     (buf_addr),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 sample, 1 sym_req, 2 sym_ack, 3 done
    typedef struct {
        int kind;
        int src;
        int addr;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  wait_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input int src, input int addr);
        ev_t e;
        e.kind = kind;
        e.src  = src;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int src, input int addr);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d actual kind=%0d src=%0d addr=%0d required none",
                     cyc, kind, src, addr);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.src != src || e.addr != addr) begin
                failures++;
                $display("FAIL event cyc=%0d actual kind=%0d src=%0d addr=%0d required kind=%0d src=%0d addr=%0d",
                         cyc, kind, src, addr, e.kind, e.src, e.addr);
            end
        end
    endtask

    // Expected event stream for one complete frame of n data symbols
    task automatic push_frame(input int n);
        for (int i = 0; i < 160; i++) push_ev(0, 1, i);
        if (n > 0) push_ev(1, 0, 0);
        for (int i = 0; i < 160; i++) push_ev(0, 2, i);
        for (int s = 0; s < n; s++) begin
            push_ev(2, 0, 0);
            if (s < n - 1) push_ev(1, 0, 0);
            for (int k = 0; k < 80; k++) push_ev(0, 3, (48 + k) % 64);
        end
        push_ev(3, 0, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},     int'(busy),         0);
        chk({tag, "_valid"},    int'(sample_valid), 0);
        chk({tag, "_src"},      int'(src_sel),      0);
        chk({tag, "_rom"},      int'(rom_addr),     0);
        chk({tag, "_buf"},      int'(buf_addr),     0);
        chk({tag, "_req"},      int'(sym_req),      0);
        chk({tag, "_ack"},      int'(sym_ack),      0);
        chk({tag, "_done"},     int'(done),         0);
        chk({tag, "_underrun"}, int'(underrun),     0);
    endtask

    // Monitor: turns DUT outputs into events (ack, req, sample, done order) and scores them
    initial begin
        bit prev_req;
        bit prev_ack;
        bit prev_done;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sym_ack === 1'b1) begin
                chk("ack_width", int'(prev_ack), 0);
                observe(2, 0, 0);
            end
            if (sym_req === 1'b1) begin
                chk("req_width", int'(prev_req), 0);
                observe(1, 0, 0);
            end
            if (en === 1'b1 && sample_valid === 1'b1) begin
                observe(0, int'(src_sel), (src_sel == 2'd3) ? int'(buf_addr) : int'(rom_addr));
            end
            if (done === 1'b1) begin
                chk("done_width", int'(prev_done), 0);
                observe(3, 0, 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (en === 1'b1 && busy === 1'b1 && sample_valid === 1'b0 && src_sel == 2'd0) begin
                wait_cnt++;
            end
            prev_req  = (sym_req === 1'b1);
            prev_ack  = (sym_ack === 1'b1);
            prev_done = (done === 1'b1);
        end
    end

    // One frame: start at relative cycle 0, run a bounded number of cycles, then score
    task automatic run_frame(input int n, input bit tog, input int stall_lo, input int stall_hi,
                             input int restart_at, input int reset_at, input int exp_done,
                             input int exp_wait, input int exp_unr);
        int t0;
        push_frame(n);
        @(posedge clk); #1;
        en          = 1'b1;
        start       = 1'b1;
        num_symbols = 8'(n);
        sym_ready   = 1'b1;
        t0          = cyc;
        done_cnt    = 0;
        wait_cnt    = 0;
        for (int rel = 1; rel <= exp_done + 3; rel++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            en        = tog ? (rel % 2 == 0) : 1'b1;
            sym_ready = !(rel >= stall_lo && rel <= stall_hi);
            if (rel == 1) begin
                chk("first_src",      int'(src_sel),  1);
                chk("first_rom",      int'(rom_addr), 0);
                chk("first_busy",     int'(busy),     1);
                chk("first_underrun", int'(underrun), 0);
            end
            if (rel == restart_at) begin
                start       = 1'b1;
                num_symbols = 8'd5;
            end
            if (rel == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                chk_idle("after_reset");
                chk("reset_no_done", done_cnt, 0);
                exp_q.delete();
                en = 1'b1;
                return;
            end
        end
        chk("done_count",   done_cnt,        1);
        chk("done_cycle",   done_cyc - t0,   exp_done);
        chk("wait_cycles",  wait_cnt,        exp_wait);
        chk("queue_left",   exp_q.size(),    0);
        chk("underrun_end", int'(underrun),  exp_unr);
        chk("busy_end",     int'(busy),      0);
        en = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        start       = 1'b0;
        num_symbols = 8'd0;
        sym_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;
        en    = 1'b1;

        // N=2, continuous: 480 samples, done at 481
        run_frame(2, 1'b0, -1, -2, -1, -1, 481, 0, 0);
        // N=0: preambles only
        run_frame(0, 1'b0, -1, -2, -1, -1, 321, 0, 0);
        // N=3, sym_ready low for 10 cycles before symbol 1
        run_frame(3, 1'b0, 400, 409, -1, -1, 571, 10, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("underrun_sticky", int'(underrun), 1);
        // Reset during LONG at rom_addr=50
        run_frame(2, 1'b0, -1, -2, -1, 211, 481, 0, 0);
        // Restart after reset begins cleanly in SHORT at rom_addr 0
        run_frame(0, 1'b0, -1, -2, -1, -1, 321, 0, 0);
        // en toggling, N=1: same sequence, twice as long
        run_frame(1, 1'b1, -1, -2, -1, -1, 802, 0, 0);
        // start re-pulsed during DATA is ignored
        run_frame(2, 1'b0, -1, -2, 330, -1, 481, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
